dccm_port_arbiter: RTL and testbench

- Shares the single DCCM read port and single DCCM write port between the LSU pipeline and a DMA/debug requester.
- The LSU always has priority and sees no backpressure. The DMA uses a valid/ready request and a valid/ready response.
- A starvation counter raises `lsu_hold` so the issue stage stops feeding the LSU until the DMA is served.
- Sits between the LSU's DCCM interface and the DCCM macro.

---
 rtl/dccm_port_arbiter.sv | 77 +++++++
 tb/tb_dccm_port_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/dccm_port_arbiter.sv
// dccm_port_arbiter: shares the DCCM read/write ports between the LSU (fixed priority) and a DMA/debug requester
module dccm_port_arbiter #(
  parameter int XLEN = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lsu_dccm_raddr,
  input  logic            lsu_dccm_rvalid_in,
  output logic [XLEN-1:0] lsu_dccm_rdata,
  output logic            lsu_dccm_rvalid_out,
  input  logic [XLEN-1:0] lsu_dccm_waddr,
  input  logic            lsu_dccm_wen,
  input  logic [XLEN-1:0] lsu_dccm_wdata,
  input  logic            lsu_busy,
  output logic            lsu_hold,
  input  logic            dma_req_valid,
  output logic            dma_req_ready,
  input  logic            dma_req_we,
  input  logic [XLEN-1:0] dma_req_addr,
  input  logic [XLEN-1:0] dma_req_wdata,
  output logic            dma_rsp_valid,
  input  logic            dma_rsp_ready,
  output logic [XLEN-1:0] dma_rsp_rdata,
  output logic [XLEN-1:0] dccm_raddr,
  output logic            dccm_rvalid_in,
  input  logic [XLEN-1:0] dccm_rdata,
  input  logic            dccm_rvalid_out,
  output logic [XLEN-1:0] dccm_waddr,
  output logic            dccm_wen,
  output logic [XLEN-1:0] dccm_wdata
);
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;
  state_t          state_q;
  logic            rsp_owner_q, hold_q, hold_d, rd_hs, wr_hs;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [XLEN-1:0] rsp_rdata_q, dma_addr;
  assign dma_addr = dma_req_addr & ~XLEN'(3);
  assign rd_hs = dma_req_valid & ~dma_req_we & ~lsu_dccm_rvalid_in &
                 (state_q == IDLE | (state_q == RSP & dma_rsp_ready));
  assign wr_hs = dma_req_valid & dma_req_we & ~lsu_dccm_wen & ~lsu_busy;
  assign dma_req_ready = rd_hs | wr_hs;
  assign dccm_rvalid_in = lsu_dccm_rvalid_in | rd_hs;
  assign dccm_raddr = lsu_dccm_rvalid_in ? lsu_dccm_raddr : rd_hs ? dma_addr : '0;
  assign dccm_wen = lsu_dccm_wen | wr_hs;
  assign dccm_waddr = lsu_dccm_wen ? lsu_dccm_waddr : wr_hs ? dma_addr : '0;
  assign dccm_wdata = lsu_dccm_wen ? lsu_dccm_wdata : wr_hs ? dma_req_wdata : '0;
  // LSU read data is never delayed; only the valid is masked when the DMA owns the returning beat
  assign lsu_dccm_rdata = dccm_rdata;
  assign lsu_dccm_rvalid_out = dccm_rvalid_out & ~rsp_owner_q;
  assign dma_rsp_valid = state_q == RSP;
  assign dma_rsp_rdata = rsp_rdata_q;
  assign lsu_hold = hold_q;
  always_comb begin
    wait_cnt_d = (~dma_req_valid | dma_req_ready) ? '0 :
                 (32'(wait_cnt_q) < STARVE_LIMIT) ? wait_cnt_q + CW'(1) : wait_cnt_q;
    hold_d = (STARVE_LIMIT != 0) && (32'(wait_cnt_d) >= STARVE_LIMIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_owner_q <= 1'b0;
      wait_cnt_q  <= '0;
      hold_q      <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_owner_q <= rd_hs;
      wait_cnt_q  <= wait_cnt_d;
      hold_q      <= hold_d;
      if (state_q == RD_WAIT) rsp_rdata_q <= dccm_rdata;
      state_q <= rd_hs ? RD_WAIT :
                 state_q == RD_WAIT ? RSP :
                 (state_q == RSP && dma_rsp_ready) ? IDLE : state_q;
    end
  end
endmodule

// File: tb/tb_dccm_port_arbiter.sv
// tb_dccm_port_arbiter: random traffic against a transaction-level model of the arbiter and a DCCM
module tb_dccm_port_arbiter;
  localparam int LIM = 4;
  logic        clk = 0, rst = 1;
  logic [31:0] lsu_dccm_raddr = 0, lsu_dccm_rdata, lsu_dccm_waddr = 0, lsu_dccm_wdata = 0;
  logic        lsu_dccm_rvalid_in = 0, lsu_dccm_rvalid_out, lsu_dccm_wen = 0, lsu_busy = 0, lsu_hold;
  logic        dma_req_valid = 0, dma_req_ready, dma_req_we = 0, dma_rsp_valid, dma_rsp_ready = 0;
  logic [31:0] dma_req_addr = 0, dma_req_wdata = 0, dma_rsp_rdata;
  logic [31:0] dccm_raddr, dccm_rdata, dccm_waddr, dccm_wdata;
  logic        dccm_rvalid_in, dccm_rvalid_out, dccm_wen;
  logic [31:0] mem [64];
  logic [31:0] rm [64];
  int          checks = 0, errors = 0;
  dccm_port_arbiter #(.XLEN(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .lsu_dccm_raddr(lsu_dccm_raddr), .lsu_dccm_rvalid_in(lsu_dccm_rvalid_in),
    .lsu_dccm_rdata(lsu_dccm_rdata), .lsu_dccm_rvalid_out(lsu_dccm_rvalid_out),
    .lsu_dccm_waddr(lsu_dccm_waddr), .lsu_dccm_wen(lsu_dccm_wen), .lsu_dccm_wdata(lsu_dccm_wdata),
    .lsu_busy(lsu_busy), .lsu_hold(lsu_hold),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_ready(dma_rsp_ready), .dma_rsp_rdata(dma_rsp_rdata),
    .dccm_raddr(dccm_raddr), .dccm_rvalid_in(dccm_rvalid_in), .dccm_rdata(dccm_rdata),
    .dccm_rvalid_out(dccm_rvalid_out), .dccm_waddr(dccm_waddr), .dccm_wen(dccm_wen),
    .dccm_wdata(dccm_wdata)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h9E3779B1);
  endfunction
  // DCCM macro: one-cycle read, read-before-write on a same-address collision
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      dccm_rvalid_out <= 1'b0;
      dccm_rdata <= '0;
    end else begin
      dccm_rvalid_out <= dccm_rvalid_in;
      if (dccm_rvalid_in) dccm_rdata <= mem[dccm_raddr[7:2]];
      if (dccm_wen) mem[dccm_waddr[7:2]] <= dccm_wdata;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  initial begin
    bit          have_pend = 0, prev_lr = 0, rd_ok, wr_ok, rsp_v;
    logic [31:0] pend_data = 0, last_rdata = 0, prev_ldata = 0, da, exp_ra, exp_wa, exp_wd;
    int          due = 0, cyc = 0, blk = 0, ph;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ph = (n / 500) % 3;
      rst = (n < 2) || ($urandom_range(0, 199) == 0);
      lsu_dccm_rvalid_in = $urandom_range(0, 99) < (ph == 2 ? 93 : 40);
      lsu_dccm_raddr = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      lsu_dccm_wen = $urandom_range(0, 99) < 30;
      lsu_dccm_waddr = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      lsu_dccm_wdata = $urandom;
      lsu_busy = $urandom_range(0, 99) < 30;
      dma_req_valid = $urandom_range(0, 99) < 65;
      dma_req_we = $urandom_range(0, 1) == 1;
      dma_req_addr = {24'b0, 8'($urandom)};
      dma_req_wdata = $urandom;
      dma_rsp_ready = $urandom_range(0, 99) < (ph == 1 ? 15 : 70);
      #1;
      da = dma_req_addr & ~32'd3;
      rsp_v = have_pend && cyc >= due;
      rd_ok = dma_req_valid && !dma_req_we && !lsu_dccm_rvalid_in && (!have_pend || (rsp_v && dma_rsp_ready));
      wr_ok = dma_req_valid && dma_req_we && !lsu_dccm_wen && !lsu_busy;
      exp_ra = lsu_dccm_rvalid_in ? lsu_dccm_raddr : rd_ok ? da : 32'd0;
      exp_wa = lsu_dccm_wen ? lsu_dccm_waddr : wr_ok ? da : 32'd0;
      exp_wd = lsu_dccm_wen ? lsu_dccm_wdata : wr_ok ? dma_req_wdata : 32'd0;
      if (n > 0) begin
        chk("req_ready", 32'(dma_req_ready), 32'(rd_ok | wr_ok));
        chk("rsp_valid", 32'(dma_rsp_valid), 32'(rsp_v));
        chk("rsp_rdata", dma_rsp_rdata, last_rdata);
        chk("lsu_hold", 32'(lsu_hold), 32'(blk >= LIM));
        chk("rd_en", 32'(dccm_rvalid_in), 32'(lsu_dccm_rvalid_in | rd_ok));
        chk("raddr", dccm_raddr, exp_ra);
        chk("wen", 32'(dccm_wen), 32'(lsu_dccm_wen | wr_ok));
        chk("waddr", dccm_waddr, exp_wa);
        chk("wdata", dccm_wdata, exp_wd);
        chk("lsu_rvalid", 32'(lsu_dccm_rvalid_out), 32'(prev_lr));
        if (prev_lr) chk("lsu_rdata", lsu_dccm_rdata, prev_ldata);
      end
      if (rst) begin
        have_pend = 0; prev_lr = 0; blk = 0; last_rdata = 0;
        for (int i = 0; i < 64; i++) rm[i] = init_word(i);
      end else begin
        if (rsp_v && dma_rsp_ready) have_pend = 0;
        if (rd_ok) begin
          have_pend = 1;
          pend_data = rm[da[7:2]];
          due = cyc + 2;
        end
        blk = (dma_req_valid && !(rd_ok || wr_ok)) ? (blk < LIM ? blk + 1 : LIM) : 0;
        prev_lr = lsu_dccm_rvalid_in;
        prev_ldata = rm[lsu_dccm_raddr[7:2]];
        if (lsu_dccm_wen) rm[lsu_dccm_waddr[7:2]] = lsu_dccm_wdata;
        else if (wr_ok) rm[da[7:2]] = dma_req_wdata;
      end
      cyc++;
      if (have_pend && cyc == due) last_rdata = pend_data;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
